mig_seq_evaluator: RTL and testbench
====================================

Name: mig_seq_evaluator

Overview:
- Programmable majority-inverter-graph (MIG) evaluator for the function-classification flow; successor to fixed 7-input MAJ3 netlists.
- Holds a configurable list of NUM_NODES MAJ3 nodes with per-operand complement, then evaluates them time-multiplexed, one node per cycle.
- EVAL mode: evaluates one input vector. SWEEP mode: enumerates all 2^NUM_IN vectors and returns the full truth table for classification.

Parameters:
- NUM_IN, 7, number of primary inputs x0..x(NUM_IN-1).
- NUM_NODES, 8, number of MAJ3 node slots.
- SEL_W, $clog2(1+NUM_IN+NUM_NODES), localparam; operand select width.
- CFG_W, 3*SEL_W+3, localparam; node config word width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  config write strobe; accepted only when busy=0.
- cfg_addr  in  $clog2(NUM_NODES+1)  0..NUM_NODES-1 selects a node; NUM_NODES selects the output register.
- cfg_data  in  CFG_W  node: {cA,cB,cC,selA,selB,selC}. Output register: low SEL_W+1 bits = {cOut,selOut}.
- start  in  1  launch request; sampled only in IDLE.
- mode  in  1  0=EVAL, 1=SWEEP; sampled with start.
- vec_in  in  NUM_IN  input vector for EVAL; sampled with start.
- busy  out  1  high from the edge after start until done.
- done  out  1  one-cycle completion pulse.
- result  out  1  EVAL result; holds until the next start.
- tt_out  out  2^NUM_IN  truth table; bit v = f(vector v). Holds until the next SWEEP start.
- err  out  1  sticky forward-reference flag; cleared on start.

Behaviour:
- Signal index space: 0 = constant 0; 1..NUM_IN = x0..; NUM_IN+1+k = node k. Indices beyond the last node read 0.
- Node k computes MAJ(a^cA, b^cB, c^cC).
- Forward or self reference (select index >= NUM_IN+1+k) reads 0 and sets err.
- Reset: FSM to IDLE; busy, done, result, err = 0; tt_out = 0; node values = 0; all config words = 0 (each node is MAJ(0,0,0); output select = 0).
- FSM states: IDLE, RUN, CAPT, FIN.
- IDLE -> RUN on start. Node index k cleared; in SWEEP the vector counter is cleared.
- RUN: node k is evaluated and registered at each edge, k = 0..NUM_NODES-1, then -> CAPT.
- CAPT: output = sel(selOut)^cOut.
  - EVAL: output goes to result, then -> FIN.
  - SWEEP: output goes to tt_out[v]. If v = 2^NUM_IN-1, -> FIN; otherwise v increments, k clears, -> RUN.
- FIN: done=1 for one cycle, busy=0, -> IDLE.
- Latency: EVAL done asserts NUM_NODES+2 edges after the start edge. SWEEP: 2^NUM_IN*(NUM_NODES+1)+1 edges.
- Vector counter has NUM_IN+1 bits, so wrap-around is detected without aliasing.
- start or cfg_we while busy: ignored. No queueing.
- start and cfg_we together in IDLE: the config write happens and the run starts. The run uses the new config.
- Reset mid-run: immediate abort to the reset state; no done pulse.

Optional Feature:
- Macro MIG_SEQ_SWEEP_EN.
- Defined: SWEEP mode and tt_out are as above.
- Undefined: the vector counter and tt register are not built; tt_out is tied 0. start with mode=1 performs no run and pulses err; busy stays 0 and done stays 0.

Decomposition:
- Shared package mig_pkg holds:
  - typedef mig_node_cfg_t (packed struct: c bits and selects);
  - enum mig_state_e {IDLE,RUN,CAPT,FIN};
  - enum mig_mode_e;
  - function sel_w(nin,nnodes).
- One natural sub-module, mig_node_alu: combinational operand muxes, complement, MAJ3 and forward-reference check for one node slot per cycle.

Test Plan:
- Node0 = MAJ(x4,x5,x6), output = node0, EVAL vec_in=7'h30 -> result=1. done pulses exactly 10 edges after start (NUM_NODES=8); busy high for 9 cycles.
- Same config, EVAL vec_in=7'h10 -> result=0. Then set cOut=1 and repeat -> result=1.
- Node0 = MAJ(~const0,x0,x1) (an OR), SWEEP -> tt_out[3:0]=4'b1110 and tt_out popcount=96.
- Node0 = MAJ(x0,x1,x2), node1 = MAJ(node0,x3,const0), out=node1, SWEEP -> tt_out[15:0]=16'hE800. done at edge 128*9+1=1153.
- Node2 selA = node5 (forward reference) -> err=1 after the run. The operand reads 0; result matches the model with 0 substituted.
- Assert rst mid-SWEEP -> busy=0, done never pulses, tt_out=0, config cleared. start and cfg_we pulses while busy are ignored (verify config unchanged, single done).

Source files
------------

// File: rtl/mig_pkg.sv
// rtl/mig_pkg.sv - shared types and helpers for the MIG sequential evaluator
package mig_pkg;

    function automatic int sel_w(input int nin, input int nnodes);
        return $clog2(1 + nin + nnodes);
    endfunction

    localparam int MIG_NUM_IN    = 7;
    localparam int MIG_NUM_NODES = 8;
    localparam int MIG_SEL_W     = sel_w(MIG_NUM_IN, MIG_NUM_NODES);

    typedef struct packed {
        logic                 ca;
        logic                 cb;
        logic                 cc;
        logic [MIG_SEL_W-1:0] sela;
        logic [MIG_SEL_W-1:0] selb;
        logic [MIG_SEL_W-1:0] selc;
    } mig_node_cfg_t;

    typedef enum logic [1:0] {IDLE, RUN, CAPT, FIN} mig_state_e;

    typedef enum logic {MODE_EVAL = 1'b0, MODE_SWEEP = 1'b1} mig_mode_e;

endpackage

// File: rtl/mig_node_alu.sv
// rtl/mig_node_alu.sv - operand muxes, complement, MAJ3 and forward-reference check for one node
module mig_node_alu
    import mig_pkg::*;
#(
    parameter int NUM_IN    = 7,
    parameter int NUM_NODES = 8,
    parameter int SEL_W     = sel_w(NUM_IN, NUM_NODES),
    parameter int KW        = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic [2:0]          cpl,
    input  logic [SEL_W-1:0]    sel_a,
    input  logic [SEL_W-1:0]    sel_b,
    input  logic [SEL_W-1:0]    sel_c,
    input  logic [KW-1:0]       k,
    input  logic [2**SEL_W-1:0] sig,
    output logic                val,
    output logic                fref
);
    logic [SEL_W:0] lim;
    logic           fr_a, fr_b, fr_c;
    logic           a, b, c;

    always_comb begin
        // node k may only read indices strictly below its own slot
        lim  = (SEL_W+1)'(NUM_IN + 1) + (SEL_W+1)'(k);
        fr_a = {1'b0, sel_a} >= lim;
        fr_b = {1'b0, sel_b} >= lim;
        fr_c = {1'b0, sel_c} >= lim;
        a    = (fr_a ? 1'b0 : sig[sel_a]) ^ cpl[2];
        b    = (fr_b ? 1'b0 : sig[sel_b]) ^ cpl[1];
        c    = (fr_c ? 1'b0 : sig[sel_c]) ^ cpl[0];
        val  = (a & b) | (a & c) | (b & c);
        fref = fr_a | fr_b | fr_c;
    end
endmodule

// File: rtl/mig_seq_evaluator.sv
// rtl/mig_seq_evaluator.sv - time-multiplexed programmable MIG evaluator; SWEEP mode under MIG_SEQ_SWEEP_EN
module mig_seq_evaluator
    import mig_pkg::*;
#(
    parameter int NUM_IN    = 7,
    parameter int NUM_NODES = 8,
    localparam int SEL_W    = sel_w(NUM_IN, NUM_NODES),
    localparam int CFG_W    = 3 * SEL_W + 3,
    localparam int AW       = $clog2(NUM_NODES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [CFG_W-1:0]     cfg_data,
    input  logic                 start,
    input  logic                 mode,
    input  logic [NUM_IN-1:0]    vec_in,
    output logic                 busy,
    output logic                 done,
    output logic                 result,
    output logic [2**NUM_IN-1:0] tt_out,
    output logic                 err
);
    localparam int KW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int NV = 2 ** NUM_IN;

    mig_state_e                     state, state_n;
    logic [NUM_NODES-1:0][CFG_W-1:0] cfg_q;
    logic [SEL_W:0]                 out_cfg;
    logic [NUM_NODES-1:0]           node_q;
    logic [NUM_IN-1:0]              vec_q;
    logic [KW-1:0]                  k_q;
    logic [2**SEL_W-1:0]            sig;
    logic [CFG_W-1:0]               cur;
    logic                           alu_val, alu_fref, out_val, k_last;

`ifdef MIG_SEQ_SWEEP_EN
    mig_mode_e                      mode_q;
    logic [NUM_IN:0]                v_q;
    logic [NV-1:0]                  tt_q;
    logic                           v_last;
    assign v_last = (v_q == (NUM_IN+1)'(NV - 1));
    assign tt_out = tt_q;
`else
    assign tt_out = '0;
`endif

    // index space: 0 = const0, then inputs, then nodes, then zero padding
    always_comb begin
        sig = '0;
        sig[NUM_IN:1] = vec_q;
        sig[NUM_IN+NUM_NODES:NUM_IN+1] = node_q;
    end

    assign cur     = cfg_q[k_q];
    assign k_last  = (k_q == KW'(NUM_NODES - 1));
    assign out_val = sig[out_cfg[SEL_W-1:0]] ^ out_cfg[SEL_W];

    mig_node_alu #(.NUM_IN(NUM_IN), .NUM_NODES(NUM_NODES), .SEL_W(SEL_W), .KW(KW)) u_alu (
        .cpl   (cur[CFG_W-1 -: 3]),
        .sel_a (cur[3*SEL_W-1 -: SEL_W]),
        .sel_b (cur[2*SEL_W-1 -: SEL_W]),
        .sel_c (cur[SEL_W-1:0]),
        .k     (k_q),
        .sig   (sig),
        .val   (alu_val),
        .fref  (alu_fref)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
`ifdef MIG_SEQ_SWEEP_EN
                if (start) state_n = RUN;
`else
                if (start && mode == MODE_EVAL) state_n = RUN;
`endif
            end
            RUN:  if (k_last) state_n = CAPT;
            CAPT: begin
`ifdef MIG_SEQ_SWEEP_EN
                if (mode_q == MODE_SWEEP && !v_last) state_n = RUN;
                else                                 state_n = FIN;
`else
                state_n = FIN;
`endif
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q   <= '0;
            out_cfg <= '0;
            node_q  <= '0;
            vec_q   <= '0;
            k_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= 1'b0;
            err     <= 1'b0;
`ifdef MIG_SEQ_SWEEP_EN
            mode_q  <= MODE_EVAL;
            v_q     <= '0;
            tt_q    <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (cfg_we && !busy) begin
                if (cfg_addr < AW'(NUM_NODES))       cfg_q[cfg_addr[KW-1:0]] <= cfg_data;
                else if (cfg_addr == AW'(NUM_NODES)) out_cfg <= cfg_data[SEL_W:0];
            end
            case (state)
                IDLE: if (start) begin
                    if (mode == MODE_EVAL) begin
                        busy  <= 1'b1;
                        err   <= 1'b0;
                        k_q   <= '0;
                        vec_q <= vec_in;
`ifdef MIG_SEQ_SWEEP_EN
                        mode_q <= MODE_EVAL;
`endif
                    end else begin
`ifdef MIG_SEQ_SWEEP_EN
                        busy   <= 1'b1;
                        err    <= 1'b0;
                        k_q    <= '0;
                        vec_q  <= '0;
                        v_q    <= '0;
                        mode_q <= MODE_SWEEP;
`else
                        err    <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    node_q[k_q] <= alu_val;
                    if (alu_fref) err <= 1'b1;
                    k_q <= k_last ? '0 : k_q + 1'b1;
                end
                CAPT: begin
`ifdef MIG_SEQ_SWEEP_EN
                    if (mode_q == MODE_SWEEP) begin
                        tt_q[v_q[NUM_IN-1:0]] <= out_val;
                        if (v_last) begin
                            busy <= 1'b0;
                        end else begin
                            v_q   <= v_q + 1'b1;
                            vec_q <= vec_q + 1'b1;
                            k_q   <= '0;
                        end
                    end else begin
                        result <= out_val;
                        busy   <= 1'b0;
                    end
`else
                    result <= out_val;
                    busy   <= 1'b0;
`endif
                end
                FIN:     done <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mig_seq_evaluator.sv
// tb/tb_mig_seq_evaluator.sv - directed table-driven bench for mig_seq_evaluator
module tb_mig_seq_evaluator;
    import mig_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_we;
    logic [3:0]   cfg_addr;
    logic [14:0]  cfg_data;
    logic         start;
    logic         mode;
    logic [6:0]   vec_in;
    logic         busy, done, result, err;
    logic [127:0] tt_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mig_seq_evaluator dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .mode(mode), .vec_in(vec_in), .busy(busy), .done(done),
        .result(result), .tt_out(tt_out), .err(err)
    );

    typedef struct {
        logic [14:0] n0;
        logic [14:0] oc;
        logic [6:0]  v;
        logic        exp;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] nd(input bit ca, input bit cb, input bit cc,
                                       input int sa, input int sb, input int sc);
        mig_node_cfg_t n;
        n.ca = ca; n.cb = cb; n.cc = cc;
        n.sela = 4'(sa); n.selb = 4'(sb); n.selc = 4'(sc);
        return n;
    endfunction

    function automatic logic [14:0] oc(input bit c, input int s);
        return 15'({c, 4'(s)});
    endfunction

    task automatic wr(input int addr, input logic [14:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic run(input logic m, input logic [6:0] v, input logic we, input logic [14:0] wd,
                       input int budget, output int edges, output int busy_cnt);
        @(negedge clk);
        start = 1'b1; mode = m; vec_in = v;
        cfg_we = we; cfg_addr = 4'd0; cfg_data = wd;
        @(posedge clk); #1;
        start = 1'b0; cfg_we = 1'b0;
        busy_cnt = int'(busy);
        edges = 0;
        while (!done && edges < budget) begin
            @(posedge clk); #1;
            edges++;
            if (busy) busy_cnt++;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL run_timeout: no done after %0d edges", edges);
        end
    endtask

    initial begin
        int edges, bc, dcnt;

        tbl[0] = '{nd(0,0,0,5,6,7), oc(0,8),  7'h30, 1'b1};
        tbl[1] = '{nd(0,0,0,5,6,7), oc(0,8),  7'h10, 1'b0};
        tbl[2] = '{nd(0,0,0,5,6,7), oc(1,8),  7'h10, 1'b1};
        tbl[3] = '{nd(1,0,0,0,1,2), oc(0,8),  7'h01, 1'b1};
        tbl[4] = '{nd(1,0,0,0,1,2), oc(0,8),  7'h00, 1'b0};
        tbl[5] = '{nd(1,0,0,0,1,2), oc(0,8),  7'h02, 1'b1};
        tbl[6] = '{nd(0,0,0,1,2,0), oc(0,8),  7'h03, 1'b1};
        tbl[7] = '{nd(0,0,0,1,2,0), oc(0,8),  7'h01, 1'b0};
        tbl[8] = '{nd(0,0,0,1,2,0), oc(0,4),  7'h08, 1'b1};
        tbl[9] = '{nd(0,0,0,1,2,0), oc(1,15), 7'h7f, 1'b1};

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; mode = 1'b0; vec_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_err", err, 0);
        chk("reset_tt", tt_out, 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            wr(0, tbl[i].n0);
            wr(8, tbl[i].oc);
            run(MODE_EVAL, tbl[i].v, 1'b0, '0, 50, edges, bc);
            chk($sformatf("eval_result[%0d]", i), result, tbl[i].exp);
            chk($sformatf("eval_latency[%0d]", i), edges, 10);
            if (i == 0) begin
                chk("eval_busy_cycles", bc, 9);
                chk("eval_err_clean", err, 0);
            end
        end

        // node2 reads node5 (forward): operand forced to 0, then complemented
        wr(2, nd(1,0,0,13,1,2));
        wr(8, oc(0,10));
        run(MODE_EVAL, 7'h01, 1'b0, '0, 50, edges, bc);
        chk("fwd_result", result, 1);
        chk("fwd_err", err, 1);
        wr(2, '0);
        run(MODE_EVAL, 7'h00, 1'b0, '0, 50, edges, bc);
        chk("fwd_err_cleared", err, 0);
        chk("fwd_clean_result", result, 0);

        // start/cfg_we while busy are dropped
        wr(0, nd(0,0,0,1,2,3));
        wr(8, oc(0,8));
        @(negedge clk); start = 1'b1; mode = MODE_EVAL; vec_in = 7'h03;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = '0; start = 1'b1; vec_in = 7'h00;
        @(negedge clk); cfg_we = 1'b0; start = 1'b0;
        dcnt = 0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("busy_single_done", dcnt, 1);
        chk("busy_result", result, 1);
        run(MODE_EVAL, 7'h03, 1'b0, '0, 50, edges, bc);
        chk("busy_cfg_unchanged", result, 1);

        // config write together with start: run sees the new (inverted) node
        run(MODE_EVAL, 7'h03, 1'b1, nd(1,1,1,1,2,3), 50, edges, bc);
        chk("same_edge_cfg", result, 0);

`ifdef MIG_SEQ_SWEEP_EN
        wr(0, nd(1,0,0,0,1,2));
        wr(8, oc(0,8));
        run(MODE_SWEEP, 7'h00, 1'b0, '0, 2000, edges, bc);
        chk("sweep_or_low", tt_out[3:0], 4'b1110);
        chk("sweep_or_pop", $countones(tt_out), 96);
        wr(0, nd(0,0,0,1,2,3));
        wr(1, nd(0,0,0,8,4,0));
        wr(8, oc(0,9));
        run(MODE_SWEEP, 7'h00, 1'b0, '0, 2000, edges, bc);
        chk("sweep_e800", tt_out, {8{16'hE800}});
        chk("sweep_latency", edges, 1153);
        @(negedge clk); start = 1'b1; mode = MODE_SWEEP;
`else
        @(negedge clk); start = 1'b1; mode = MODE_SWEEP;
        @(posedge clk); #1;
        start = 1'b0;
        chk("nosweep_err", err, 1);
        chk("nosweep_busy", busy, 0);
        dcnt = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (done || busy) dcnt++;
        end
        chk("nosweep_no_run", dcnt, 0);
        chk("nosweep_tt", tt_out, 0);
        wr(8, oc(0,8));
        @(negedge clk); start = 1'b1; mode = MODE_EVAL;
`endif

        // reset mid-run aborts and clears configuration
        @(negedge clk); start = 1'b0;
        wr(8, oc(1,0));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_tt", tt_out, 0);
        chk("rst_done", done, 0);
        @(negedge clk); rst = 1'b0;
        dcnt = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("rst_no_done", dcnt, 0);
        run(MODE_EVAL, 7'h7f, 1'b0, '0, 50, edges, bc);
        chk("rst_cfg_cleared", result, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
